// File: rtl/fpu_pkg.sv
// Shared constants and state encoding for the iterative FPU stages.
package fpu_pkg;

    localparam int FP32_FRAC_WIDTH = 24;  // significand incl. hidden bit
    localparam int FP32_EXP_WIDTH  = 8;

    // Common encoding for multi-cycle FPU stages.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } iterState_t;

    // Integer ceiling division, used to size per-cycle slices.
    function automatic int ceilDiv(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

endpackage

// File: rtl/fp_mant_mult_iter_if.sv
// Operand/result bundle between the unpack stage, the iterative
// mantissa multiplier and the normalize/round stage.
interface fp_mant_mult_iter_if #(
    parameter int FRAC_WIDTH = 24
);
    logic                    validIn;
    logic [FRAC_WIDTH-1:0]   mantAIn;
    logic [FRAC_WIDTH-1:0]   mantBIn;
    logic                    busyOut;
    logic                    validOut;
    logic [2*FRAC_WIDTH-1:0] prodOut;

    // Upstream side: issues operands, observes status and product.
    modport master (
        output validIn, mantAIn, mantBIn,
        input  busyOut, validOut, prodOut
    );

    // Multiplier side.
    modport slave (
        input  validIn, mantAIn, mantBIn,
        output busyOut, validOut, prodOut
    );
endinterface

// File: rtl/fp_mant_mult_iter_chunk.sv
// Combinational partial product of the full multiplicand with one
// BPC-bit slice of the multiplier, built as a shift-add over slice bits.
module fp_chunk_pprod #(
    parameter int FRAC_WIDTH = 24,
    parameter int BPC        = 6
) (
    input  logic [FRAC_WIDTH-1:0]     mantIn,
    input  logic [BPC-1:0]            sliceIn,
    output logic [FRAC_WIDTH+BPC-1:0] pprodOut
);
    localparam int PP_W = FRAC_WIDTH + BPC;

    // Sum the multiplicand shifted by each set slice bit.
    always_comb begin
        pprodOut = '0;
        for (int i = 0; i < BPC; i++) begin
            if (sliceIn[i]) begin
                pprodOut = pprodOut + (PP_W'(mantIn) << i);
            end
        end
    end
endmodule

// File: rtl/fp_mant_mult_iter.sv
// Iterative unsigned significand multiplier: consumes BPC multiplier
// bits per clock and accumulates A*B over MULT_CYCLES clocks.
module fp_mant_mult_iter
    import fpu_pkg::*;
#(
    parameter int FRAC_WIDTH  = FP32_FRAC_WIDTH,
    parameter int MULT_CYCLES = 4
) (
    input logic               clkIn,
    input logic               rstIn,
    fp_mant_mult_iter_if.slave bus
);
    localparam int BPC    = ceilDiv(FRAC_WIDTH, MULT_CYCLES);
    localparam int PAD_W  = MULT_CYCLES * BPC;          // B zero-extended to whole slices
    localparam int ACC_W  = 2 * FRAC_WIDTH;
    localparam int PP_W   = FRAC_WIDTH + BPC;
    localparam int WIDE_W = FRAC_WIDTH + PAD_W;         // never narrower than ACC_W
    localparam int CNT_W  = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_CYCLES - 1);

    iterState_t            state, stateNext;
    logic [CNT_W-1:0]      cnt;
    logic [FRAC_WIDTH-1:0] aReg;
    logic [PAD_W-1:0]      bReg;
    logic [ACC_W-1:0]      acc;
    logic [BPC-1:0]        chunk;
    logic [PP_W-1:0]       pprod;
    logic [WIDE_W-1:0]     pprodShifted;
    logic                  accept;

    // New operands are taken only when idle or in the result cycle.
    assign accept = bus.validIn && ((state == IDLE) || (state == DONE));

    // Select the multiplier slice for this iteration and align its product.
    always_comb begin
        chunk        = bReg[int'(cnt) * BPC +: BPC];
        pprodShifted = WIDE_W'(pprod) << (int'(cnt) * BPC);
    end

    fp_chunk_pprod #(
        .FRAC_WIDTH (FRAC_WIDTH),
        .BPC        (BPC)
    ) uChunk (
        .mantIn   (aReg),
        .sliceIn  (chunk),
        .pprodOut (pprod)
    );

    // State register.
    always_ff @(posedge clkIn) begin
        if (rstIn) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state logic: IDLE -> RUN -> DONE -> (RUN | IDLE).
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.validIn) stateNext = RUN;
            RUN:     if (cnt == LAST_CNT) stateNext = DONE;
            DONE:    stateNext = bus.validIn ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Operand capture, slice counter and accumulator.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            cnt  <= '0;
            acc  <= '0;
            aReg <= '0;
            bReg <= '0;
        end else if (accept) begin
            aReg <= bus.mantAIn;
            bReg <= PAD_W'(bus.mantBIn);
            acc  <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            // The true product fits ACC_W, so dropping high zero bits is exact.
            acc <= acc + pprodShifted[ACC_W-1:0];
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        end
    end

    assign bus.busyOut  = (state == RUN);
    assign bus.validOut = (state == DONE);
    assign bus.prodOut  = acc;
endmodule

// File: tb/tb_fp_mant_mult_iter.sv
// Scoreboard bench for fp_mant_mult_iter: a 4-cycle and a 5-cycle build
// share one clock; expected products and arrival cycles are queued at
// issue time and checked by per-DUT monitors.
module tb_fp_mant_mult_iter;

    typedef struct {
        logic [47:0] prod;
        int          cyc;
    } exp_t;

    logic clkIn = 1'b0;
    logic rstIn;
    int   cyc = 0;
    int   nTests = 0;
    int   nFail  = 0;
    exp_t q4[$];
    exp_t q5[$];

    fp_mant_mult_iter_if #(.FRAC_WIDTH(24)) ifc4 ();
    fp_mant_mult_iter_if #(.FRAC_WIDTH(24)) ifc5 ();

    fp_mant_mult_iter #(.FRAC_WIDTH(24), .MULT_CYCLES(4)) dut4 (
        .clkIn (clkIn),
        .rstIn (rstIn),
        .bus   (ifc4)
    );

    fp_mant_mult_iter #(.FRAC_WIDTH(24), .MULT_CYCLES(5)) dut5 (
        .clkIn (clkIn),
        .rstIn (rstIn),
        .bus   (ifc5)
    );

    always #5 clkIn = ~clkIn;

    always @(posedge clkIn) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    // Issue one operand pair to the 4-cycle build and queue its result.
    task automatic start4(input logic [23:0] a, input logic [23:0] b, input logic [47:0] p);
        exp_t e;
        e.prod = p;
        e.cyc  = cyc + 5;
        q4.push_back(e);
        ifc4.validIn = 1'b1;
        ifc4.mantAIn = a;
        ifc4.mantBIn = b;
        tick();
        ifc4.validIn = 1'b0;
    endtask

    task automatic start5(input logic [23:0] a, input logic [23:0] b, input logic [47:0] p);
        exp_t e;
        e.prod = p;
        e.cyc  = cyc + 6;
        q5.push_back(e);
        ifc5.validIn = 1'b1;
        ifc5.mantAIn = a;
        ifc5.mantBIn = b;
        tick();
        ifc5.validIn = 1'b0;
    endtask

    // Monitor for the 4-cycle build.
    always @(negedge clkIn) begin
        if (rstIn === 1'b0 && ifc4.validOut === 1'b1) begin
            if (q4.size() == 0) begin
                check("unexpected validOut4", 64'(ifc4.validOut), 64'd0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("prod4", 64'(ifc4.prodOut), 64'(e.prod));
                check("latency4", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Monitor for the 5-cycle build.
    always @(negedge clkIn) begin
        if (rstIn === 1'b0 && ifc5.validOut === 1'b1) begin
            if (q5.size() == 0) begin
                check("unexpected validOut5", 64'(ifc5.validOut), 64'd0);
            end else begin
                exp_t e;
                e = q5.pop_front();
                check("prod5", 64'(ifc5.prodOut), 64'(e.prod));
                check("latency5", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        int guard;
        rstIn = 1'b1;
        ifc4.validIn = 1'b0; ifc4.mantAIn = '0; ifc4.mantBIn = '0;
        ifc5.validIn = 1'b0; ifc5.mantAIn = '0; ifc5.mantBIn = '0;
        repeat (3) tick();
        rstIn = 1'b0;
        tick();

        // Reset state
        check("rst busy4", 64'(ifc4.busyOut), 64'd0);
        check("rst valid4", 64'(ifc4.validOut), 64'd0);
        check("rst prod4", 64'(ifc4.prodOut), 64'd0);
        check("rst prod5", 64'(ifc5.prodOut), 64'd0);

        // 1.0 * 1.0 with busy window cycles 1-4
        start4(24'h800000, 24'h800000, 48'h4000_0000_0000);
        for (int i = 0; i < 4; i++) begin
            check("busy during run", 64'(ifc4.busyOut), 64'd1);
            tick();
        end
        check("busy in done", 64'(ifc4.busyOut), 64'd0);
        tick();
        check("idle valid", 64'(ifc4.validOut), 64'd0);

        // 1.5 * 1.5 and max operands
        start4(24'hC00000, 24'hC00000, 48'h9000_0000_0000);
        repeat (5) tick();
        start4(24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001);
        repeat (5) tick();

        // Back-to-back: second start issued in the validOut cycle
        start4(24'h800000, 24'h800000, 48'h4000_0000_0000);
        repeat (4) tick();
        check("b2b done cycle", 64'(ifc4.validOut), 64'd1);
        start4(24'hFFFFFF, 24'h800000, 48'h7FFF_FF80_0000);
        check("b2b prod cleared", 64'(ifc4.prodOut), 64'd0);
        check("b2b busy", 64'(ifc4.busyOut), 64'd1);
        repeat (5) tick();

        // validIn during RUN is ignored
        start4(24'hC00000, 24'h800000, 48'h6000_0000_0000);
        tick();
        ifc4.validIn = 1'b1;
        ifc4.mantAIn = 24'hFFFFFF;
        ifc4.mantBIn = 24'hFFFFFF;
        tick();
        ifc4.validIn = 1'b0;
        repeat (3) tick();
        repeat (4) tick();
        check("no extra start", 64'(ifc4.busyOut), 64'd0);

        // Reset in cycle 3 of RUN discards the product
        ifc4.validIn = 1'b1;
        ifc4.mantAIn = 24'hFFFFFF;
        ifc4.mantBIn = 24'hFFFFFF;
        tick();
        ifc4.validIn = 1'b0;
        repeat (2) tick();
        rstIn = 1'b1;
        tick();
        rstIn = 1'b0;
        check("midrst busy", 64'(ifc4.busyOut), 64'd0);
        check("midrst valid", 64'(ifc4.validOut), 64'd0);
        check("midrst prod", 64'(ifc4.prodOut), 64'd0);
        repeat (6) tick();
        start4(24'h800000, 24'h800000, 48'h4000_0000_0000);
        repeat (5) tick();

        // Reset and validIn on the same edge: reset wins
        rstIn = 1'b1;
        ifc4.validIn = 1'b1;
        tick();
        rstIn = 1'b0;
        ifc4.validIn = 1'b0;
        check("rst beats start", 64'(ifc4.busyOut), 64'd0);
        repeat (6) tick();

        // Five-cycle build: padding slice, zero operand, 1.5*1.5
        start5(24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001);
        repeat (6) tick();
        start5(24'h000000, 24'hFFFFFF, 48'h0);
        repeat (6) tick();
        start5(24'hC00000, 24'hC00000, 48'h9000_0000_0000);
        repeat (6) tick();

        // Drain with a bound
        guard = 0;
        while ((q4.size() != 0 || q5.size() != 0) && guard < 20) begin
            tick();
            guard++;
        end
        check("pending results", 64'(q4.size() + q5.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
